// File: rtl/clk_ratio_gen_if.sv
// Control/status bundle of the divided-clock generator: run request, half-period
// config handshake, and the generated clock with its strobes and edge count.
interface clk_ratio_gen_if #(
    parameter int CNT_W  = 8,
    parameter int EDGE_W = 16
);
    logic              en;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              clk_out;
    logic              rise_stb;
    logic              fall_stb;
    logic [EDGE_W-1:0] edge_cnt;
    logic              running;

    modport master (
        output en, cfg_half, cfg_valid,
        input  cfg_ready, clk_out, rise_stb, fall_stb, edge_cnt, running
    );

    modport slave (
        input  en, cfg_half, cfg_valid,
        output cfg_ready, clk_out, rise_stb, fall_stb, edge_cnt, running
    );
endinterface

// File: rtl/clk_ratio_gen.sv
// Glitch-free 50% duty divided clock from clk1 with run-time reprogrammable half-period,
// rise/fall strobes and a rising-edge counter. All outputs are registered.
module clk_ratio_gen #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 1,
    parameter int EDGE_W       = 16
) (
    input  logic            clk1_i,
    input  logic            rst_i,
    clk_ratio_gen_if.slave  bus_io
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              clk_out_q, clk_out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              running_q, running_d;
    logic              toggle_s;
    logic              apply_s;
    logic              take_s;

    // A half-period of zero would never toggle; treat it as the fastest setting.
    function automatic logic [CNT_W-1:0] coerce_half(input logic [CNT_W-1:0] h);
        if (h == {CNT_W{1'b0}}) begin
            coerce_half = CNT_W'(1);
        end else begin
            coerce_half = h;
        end
    endfunction

    // Next-state, counter, clock level, strobes and config handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        edge_d     = edge_q;
        apply_s    = 1'b0;
        toggle_s   = (cnt_q == (half_q - CNT_W'(1)));
        take_s     = bus_io.cfg_valid & cfg_ready_q;

        case (state_q)
            ST_IDLE: begin
                apply_s = pend_vld_q;
                cnt_d   = {CNT_W{1'b0}};
                if (bus_io.en) begin
                    clk_out_d = 1'b1;
                    rise_d    = 1'b1;
                    edge_d    = edge_q + EDGE_W'(1);
                    state_d   = ST_RUN;
                end else begin
                    clk_out_d = 1'b0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!bus_io.en && !clk_out_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (toggle_s) begin
                    // With en low here the clock is high, so this toggle is the final fall.
                    clk_out_d = ~clk_out_q;
                    rise_d    = ~clk_out_q;
                    fall_d    = clk_out_q;
                    edge_d    = clk_out_q ? edge_q : (edge_q + EDGE_W'(1));
                    cnt_d     = {CNT_W{1'b0}};
                    apply_s   = pend_vld_q;
                    state_d   = bus_io.en ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = bus_io.en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                clk_out_d = 1'b0;
            end
        endcase

        // Slot is busy while a value is pending, so capture and apply never coincide.
        if (apply_s) begin
            half_d     = pend_q;
            pend_vld_d = 1'b0;
        end else if (take_s) begin
            pend_d     = coerce_half(bus_io.cfg_half);
            pend_vld_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        cfg_ready_d = ~pend_vld_d;
        running_d   = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk1_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            half_q      <= coerce_half(CNT_W'(DEFAULT_HALF));
            pend_q      <= {CNT_W{1'b0}};
            pend_vld_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
            clk_out_q   <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            edge_q      <= {EDGE_W{1'b0}};
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            cfg_ready_q <= cfg_ready_d;
            clk_out_q   <= clk_out_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            edge_q      <= edge_d;
            running_q   <= running_d;
        end
    end

    assign bus_io.cfg_ready = cfg_ready_q;
    assign bus_io.clk_out   = clk_out_q;
    assign bus_io.rise_stb  = rise_q;
    assign bus_io.fall_stb  = fall_q;
    assign bus_io.edge_cnt  = edge_q;
    assign bus_io.running   = running_q;
endmodule
